// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO (one-cycle read latency) onto an
// 8N1-style UART line, LSB first, pacing FIFO pops to the serial bit rate.
module fifo_uart_tx #(
    parameter int unsigned DATAW        = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tx_en,
    input  logic             i_rd_empty,
    input  logic [DATAW-1:0] i_rd_data,
    output logic             o_rd_en,
    output logic             o_tx,
    output logic             o_busy
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = $clog2(DATAW + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATAW - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    // Reject parameter values the bit timing cannot support.
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q,  baud_d;
    logic [BIT_W-1:0]   bit_q,   bit_d;
    logic [DATAW-1:0]   shreg_q, shreg_d;
    logic               tx_q,    tx_d;
    logic               busy_q,  busy_d;

    logic               rd_req;
    logic               baud_tick;

    // Pop request: only from IDLE, only when permitted and data is available.
    // Held low during reset so a pop can never be issued while the FSM is
    // forced back to IDLE.
    assign rd_req    = (state_q == S_IDLE) && i_tx_en && !i_rd_empty;
    assign o_rd_en   = rd_req && !rst;
    assign baud_tick = (baud_q == BAUD_LAST);

    // State, counters, shift register and line/busy flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, counter and next-line-level logic.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (rd_req) begin
                    state_d = S_LOAD;
                end
            end

            // FIFO read data is valid in this cycle; start bit begins next.
            S_LOAD: begin
                shreg_d = i_rd_data;
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_START;
            end

            S_START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            // Bit counter is reused to count stop-bit periods.
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; a FIFO model feeds two DUTs (1 and 2
// stop bits), a frame decoder compares line bytes against pushed bytes.
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       tx_en_a = 1'b0, empty_a = 1'b1;
    logic [7:0] rd_data_a = 8'h00;
    logic       rd_en_a, tx_a, busy_a;

    logic       tx_en_b = 1'b0, empty_b = 1'b1;
    logic [7:0] rd_data_b = 8'h00;
    logic       rd_en_b, tx_b, busy_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int unsigned fifo_a[$], fifo_b[$];
    int unsigned exp_a[$],  exp_b[$];
    int pulse_a[$], pulse_b[$], start_a[$], start_b[$];
    int blen_a[$],  blen_b[$],  hrun_a[$],  hrun_b[$];
    int wide_a = 0, wide_b = 0;
    int bcnt_a = 0, bcnt_b = 0, hcnt_a = 0, hcnt_b = 0;
    logic ren_prev_a = 1'b0, ren_prev_b = 1'b0;
    logic tx_prev_a = 1'b1, tx_prev_b = 1'b1;

    fifo_uart_tx #(.DATAW(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_tx_en    (tx_en_a),
        .i_rd_empty (empty_a),
        .i_rd_data  (rd_data_a),
        .o_rd_en    (rd_en_a),
        .o_tx       (tx_a),
        .o_busy     (busy_a)
    );

    fifo_uart_tx #(.DATAW(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_tx_en    (tx_en_b),
        .i_rd_empty (empty_b),
        .i_rd_data  (rd_data_b),
        .o_rd_en    (rd_en_b),
        .o_tx       (tx_b),
        .o_busy     (busy_b)
    );

    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: registered read data, one-cycle latency after the pop.
    always @(posedge clk) begin
        if (rd_en_a && fifo_a.size() > 0) rd_data_a <= 8'(fifo_a.pop_front());
        if (rd_en_b && fifo_b.size() > 0) rd_data_b <= 8'(fifo_b.pop_front());
    end

    // FIFO empty flags settle shortly after each edge.
    always @(posedge clk) begin
        #2;
        empty_a = (fifo_a.size() == 0);
        empty_b = (fifo_b.size() == 0);
    end

    // Event monitor: pop pulses, busy run lengths, line start edges, mark runs.
    always @(negedge clk) begin
        if (rd_en_a) begin
            pulse_a.push_back(cyc);
            if (ren_prev_a) wide_a++;
        end
        ren_prev_a = rd_en_a;
        if (busy_a) bcnt_a++;
        else if (bcnt_a > 0) begin blen_a.push_back(bcnt_a); bcnt_a = 0; end
        if (tx_a) hcnt_a++;
        else begin
            if (tx_prev_a) begin start_a.push_back(cyc); hrun_a.push_back(hcnt_a); end
            hcnt_a = 0;
        end
        tx_prev_a = tx_a;

        if (rd_en_b) begin
            pulse_b.push_back(cyc);
            if (ren_prev_b) wide_b++;
        end
        ren_prev_b = rd_en_b;
        if (busy_b) bcnt_b++;
        else if (bcnt_b > 0) begin blen_b.push_back(bcnt_b); bcnt_b = 0; end
        if (tx_b) hcnt_b++;
        else begin
            if (tx_prev_b) begin start_b.push_back(cyc); hrun_b.push_back(hcnt_b); end
            hcnt_b = 0;
        end
        tx_prev_b = tx_b;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic line(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction

    task automatic push(input int sel, input logic [7:0] b);
        if (sel == 0) begin
            fifo_a.push_back(32'(b));
            exp_a.push_back(32'(b));
        end else begin
            fifo_b.push_back(32'(b));
            exp_b.push_back(32'(b));
        end
    endtask

    task automatic clear_mon();
        pulse_a.delete(); start_a.delete(); blen_a.delete(); hrun_a.delete();
        pulse_b.delete(); start_b.delete(); blen_b.delete(); hrun_b.delete();
    endtask

    task automatic wait_rd_en(input int sel, input string tag);
        int n = 0;
        while (((sel != 0) ? rd_en_b : rd_en_a) !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check({tag, "_rd_en_timeout"}, 0, 1);
    endtask

    // Decode one frame at bit resolution and score it against the next expected byte.
    task automatic rx_frame(input int sel, input string tag);
        int n = 0;
        int unsigned sb = (sel != 0) ? 2 : 1;
        int unsigned total = (9 + sb) * CPB;
        logic lv [0:63];
        logic [7:0] gb;
        int start_bad = 0, unstable = 0, stop_bad = 0;
        int unsigned expb;
        while (line(sel) !== 1'b0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (line(sel) !== 1'b0) begin
            check({tag, "_start_timeout"}, 0, 1);
            return;
        end
        for (int k = 0; k < int'(total); k++) begin
            lv[k] = line(sel);
            @(negedge clk);
        end
        for (int c = 0; c < int'(CPB); c++) if (lv[c] !== 1'b0) start_bad++;
        for (int b = 0; b < 8; b++) begin
            gb[b] = lv[(1 + b) * CPB];
            for (int c = 1; c < int'(CPB); c++)
                if (lv[(1 + b) * CPB + c] !== lv[(1 + b) * CPB]) unstable++;
        end
        for (int k = 9 * CPB; k < int'(total); k++) if (lv[k] !== 1'b1) stop_bad++;
        check({tag, "_start_bit"}, 32'(start_bad), 0);
        check({tag, "_bit_stable"}, 32'(unstable), 0);
        check({tag, "_stop_bits"}, 32'(stop_bad), 0);
        if (((sel != 0) ? exp_b.size() : exp_a.size()) == 0) begin
            check({tag, "_unexpected_frame"}, 32'(gb), 32'hFFFF_FFFF);
        end else begin
            expb = (sel != 0) ? exp_b.pop_front() : exp_a.pop_front();
            check({tag, "_byte"}, 32'(gb), expb);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0a, w0b;

        // 1: reset holds outputs idle while enables toggle
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_en_a = ~tx_en_a;
            tx_en_b = ~tx_en_b;
            #1;
            check("rst_tx_a", 32'(tx_a), 1);
            check("rst_rd_en_a", 32'(rd_en_a), 0);
            check("rst_busy_a", 32'(busy_a), 0);
            check("rst_tx_b", 32'(tx_b), 1);
            check("rst_rd_en_b", 32'(rd_en_b), 0);
            check("rst_busy_b", 32'(busy_b), 0);
        end
        @(negedge clk);
        tx_en_a = 1'b1;
        tx_en_b = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tx_a", 32'(tx_a), 1);
        check("post_rst_rd_en_a", 32'(rd_en_a), 0);
        check("post_rst_busy_a", 32'(busy_a), 0);
        check("post_rst_busy_b", 32'(busy_b), 0);
        w0a = wide_a;
        w0b = wide_b;

        // 2: single byte 0xA5
        clear_mon();
        push(0, 8'hA5);
        rx_frame(0, "a5");
        repeat (3) @(negedge clk);
        check("a5_pulses", 32'(pulse_a.size()), 1);
        check("a5_start_delay", 32'((start_a.size() > 0 && pulse_a.size() > 0) ? start_a[0] - pulse_a[0] : -1), 2);
        check("a5_busy_len", 32'((blen_a.size() > 0) ? blen_a[0] : -1), 41);

        // 3: back-to-back 0x00 then 0xFF
        clear_mon();
        push(0, 8'h00);
        push(0, 8'hFF);
        rx_frame(0, "b2b0");
        rx_frame(0, "b2b1");
        repeat (3) @(negedge clk);
        check("b2b_pulses", 32'(pulse_a.size()), 2);
        check("b2b_pulse_gap", 32'((pulse_a.size() > 1) ? pulse_a[1] - pulse_a[0] : -1), 42);
        // Mark run before 2nd start: stop (4) + IDLE + LOAD.
        check("b2b_mark_gap", 32'((hrun_a.size() > 1) ? hrun_a[1] : -1), 6);

        // 4a: empty FIFO never pops
        clear_mon();
        repeat (100) @(negedge clk);
        check("empty_no_pop", 32'(pulse_a.size()), 0);
        check("empty_no_start", 32'(start_a.size()), 0);
        check("empty_tx", 32'(tx_a), 1);

        // 4b: drop i_tx_en during DATA bit 2
        push(0, 8'h96);
        push(0, 8'h33);
        fork
            rx_frame(0, "gate0");
            begin
                wait_rd_en(0, "gate");
                repeat (15) @(negedge clk);
                tx_en_a = 1'b0;
            end
        join
        repeat (60) @(negedge clk);
        check("gate_no_pop", 32'(pulse_a.size()), 1);
        check("gate_idle_tx", 32'(tx_a), 1);
        check("gate_idle_busy", 32'(busy_a), 0);
        tx_en_a = 1'b1;
        rx_frame(0, "gate1");
        check("gate_resume_pops", 32'(pulse_a.size()), 2);

        // 5: asynchronous reset during DATA bit 3
        push(0, 8'h00);
        push(0, 8'h5A);
        wait_rd_en(0, "mrst");
        repeat (19) @(negedge clk);
        check("mrst_line_low", 32'(tx_a), 0);
        check("mrst_busy_pre", 32'(busy_a), 1);
        rst = 1'b1;
        #1;
        check("mrst_tx", 32'(tx_a), 1);
        check("mrst_busy", 32'(busy_a), 0);
        check("mrst_rd_en", 32'(rd_en_a), 0);
        void'(exp_a.pop_front());
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        rx_frame(0, "mrst_next");
        check("mrst_fresh_pop", 32'(pulse_a.size()), 1);

        // 6: two stop bits, 0x3C then 0x81
        clear_mon();
        push(1, 8'h3C);
        push(1, 8'h81);
        rx_frame(1, "sb2_0");
        rx_frame(1, "sb2_1");
        repeat (3) @(negedge clk);
        check("sb2_pulse_gap", 32'((pulse_b.size() > 1) ? pulse_b[1] - pulse_b[0] : -1), 46);
        // Mark runs: idle, bits 2..5 of 0x3C (16), then stop (8) + IDLE + LOAD.
        check("sb2_mark_gap", 32'((hrun_b.size() > 2) ? hrun_b[2] : -1), 10);
        check("sb2_busy_len", 32'((blen_b.size() > 0) ? blen_b[0] : -1), 45);

        check("rd_en_width_a", 32'(wide_a - w0a), 0);
        check("rd_en_width_b", 32'(wide_b - w0b), 0);
        check("sb_a_drained", 32'(exp_a.size()), 0);
        check("sb_b_drained", 32'(exp_b.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
